if_stage: RTL
=============

# if_stage

Instruction-fetch stage of the five-stage pipeline. Sits directly upstream of the IF/ID pipeline register.
- Owns the program counter and drives a request/acknowledge instruction-memory port.
- Produces `instr_out` and `next_pc_out` (PC+4) plus a one-cycle `valid_out` strobe used as the IF/ID load enable.
- Honours hazard-unit stalls without losing a fetched word, and honours branch/jump redirects, discarding wrong-path fetches.

## Interface
- `RESET_PC`, default 32'h0000_0000: first fetch address after reset.
- `TRAP_PC`, default 32'h0000_0080: redirect target used for misaligned redirects (see Configuration).

Ports:
- `clk`  in  1  pipeline clock; all state on rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `stall`  in  1  from hazard unit; 1 = downstream cannot accept an instruction this cycle.
- `redirect`  in  1  branch taken / jump resolved; 1-cycle pulse.
- `redirect_pc`  in  32  new fetch address, valid when `redirect`=1.
- `imem_req`  out  1  memory request.
- `imem_addr`  out  32  word address of the request.
- `imem_ack`  in  1  memory returns `imem_rdata` this cycle. Zero-wait ack is allowed in the same cycle `imem_req` first rises.
- `imem_rdata`  in  32  instruction word, valid when `imem_ack`=1.
- `valid_out`  out  1  `instr_out`/`next_pc_out` hold a new instruction this cycle.
- `instr_out`  out  32  fetched instruction.
- `next_pc_out`  out  32  fetch address + 4.
- `misalign`  out  1  exception flag (only with the macro defined, else tied 0).

## Operation
- Registers:
  - `pc`: next address to fetch.
  - `imem_addr`: address of the outstanding request.
  - `hold_instr` / `hold_npc`: one-entry buffer.
  - 2-bit state.
- States:
  - IDLE: entered on reset; leaves unconditionally to REQ next cycle, loading `imem_addr`<=`pc`.
  - REQ: `imem_req`=1, `imem_addr` stable until ack.
    - On ack with `stall`=0: register `imem_rdata` to `instr_out`, `imem_addr`+4 to `next_pc_out`, `valid_out`<=1. Set `pc`,`imem_addr`<=`imem_addr`+4. Stay in REQ.
    - On ack with `stall`=1: capture into the hold buffer, `pc`<=`imem_addr`+4, go to HOLD.
  - HOLD: `imem_req`=0. When `stall`=0, present the hold buffer with `valid_out`=1, load `imem_addr`<=`pc`, go to REQ.
  - DRAIN: `imem_req`=1 with old `imem_addr`. The returned word is discarded on ack; then load `imem_addr`<=`pc`, go to REQ.
- Redirect has priority over stall and ack, in every state. It sets `pc`<=`redirect_pc` and `valid_out`<=0.
  - REQ without ack: go to DRAIN (the outstanding request is never abandoned).
  - REQ with same-cycle ack: drop the data, `imem_addr`<=`redirect_pc`, stay in REQ.
  - HOLD: clear the buffer, `imem_addr`<=`redirect_pc`, go to REQ.
  - IDLE: load `redirect_pc` instead of `pc`.
  - DRAIN: update `pc` only; the drain completes as normal.
- `valid_out` is high for exactly one cycle per delivered instruction. `instr_out`/`next_pc_out` hold their last value while `valid_out`=0.
- Arithmetic is 32-bit unsigned with wrap: 32'hFFFF_FFFC+4 = 32'h0000_0000, with no flag.

## Timing
- Reset values (asynchronous):
  - State IDLE, `pc`=`RESET_PC`, `imem_addr`=`RESET_PC`.
  - `imem_req`=0, `valid_out`=0, `misalign`=0.
  - `instr_out`=32'h0000_0000 (NOP), `next_pc_out`=0.
- Reset asserted mid-request: outputs return to reset values immediately; any in-flight ack after release is ignored until REQ.
- Latency:
  - First edge after reset release: IDLE→REQ.
  - With zero-wait memory, `valid_out` first rises one cycle after the ack, i.e. the third cycle after release.
  - Steady state is one instruction per cycle.
- Ack→`valid_out` is always one cycle. Stall release→`valid_out` (from HOLD) is one cycle.
- Redirect→first correct-path `valid_out` with zero-wait memory is two cycles (REQ same-cycle-ack or HOLD case). The DRAIN case adds the remaining memory latency plus one.

## Configuration
- Macro: `IF_STAGE_MISALIGN_TRAP_EN`.
  - Defined: a redirect with `redirect_pc[1:0]`≠0 is replaced by `TRAP_PC` and asserts `misalign` for one cycle, in the same cycle the redirect is registered.
  - Undefined: `redirect_pc[1:0]` is forced to 2'b00, and `misalign` is constant 0.

## Test plan
- Reset release, zero-wait memory returning addr as data -> `imem_addr` 0,4,8…; `valid_out` from cycle 3; `instr_out`=0,4,8 with `next_pc_out`=4,8,12.
- `stall`=1 for 3 cycles arriving with ack at addr 0x10 -> no `valid_out` during the stall, `imem_req`=0; one cycle after release `instr_out`=word@0x10, `next_pc_out`=0x14; next fetch 0x14.
- 3-cycle memory, `redirect` to 0x200 one cycle after a request to 0x40 -> 0x40 data discarded, no `valid_out` for it; next `imem_addr`=0x200.
- `redirect` to 0x300 coinciding with ack and `stall`=1 -> no HOLD entry, `valid_out` stays 0, next request at 0x300.
- `pc` at 0xFFFF_FFFC -> `next_pc_out`=0, next fetch at 0x0.
- Macro defined, `redirect_pc`=0x102 -> `misalign`=1 for one cycle, next fetch 0x80. Macro undefined -> fetch 0x100, `misalign`=0.

Source files
------------

// File: rtl/if_stage_if.sv
// Instruction-memory request/acknowledge port between the fetch stage and memory.
// imem_addr stays stable while imem_req=1 until the cycle imem_ack=1; ack may come in the first request cycle.
interface if_stage_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;

    modport master (output imem_req, output imem_addr, input imem_ack, input imem_rdata);
    modport slave  (input imem_req, input imem_addr, output imem_ack, output imem_rdata);
endinterface

// File: rtl/if_stage.sv
// Instruction-fetch stage: owns the PC, fetches over if_stage_if, buffers one word across stalls.
// Optional macro IF_STAGE_MISALIGN_TRAP_EN: misaligned redirects go to TRAP_PC and pulse misalign.
module if_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] TRAP_PC  = 32'h0000_0080
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        stall,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    if_stage_if.master  imem,
    output logic        valid_out,
    output logic [31:0] instr_out,
    output logic [31:0] next_pc_out,
    output logic        misalign,
    output logic [1:0]  dbg_state
);
    typedef enum logic [1:0] {IDLE = 2'd0, REQ = 2'd1, HOLD = 2'd2, DRAIN = 2'd3} state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] hold_instr_q, hold_instr_d;
    logic [31:0] hold_npc_q, hold_npc_d;
    logic [31:0] instr_q, instr_d;
    logic [31:0] npc_q, npc_d;
    logic        valid_q, valid_d;
    logic        misalign_q, misalign_d;
    logic        redir_bad;
    logic [31:0] redir_tgt;
    logic [31:0] addr_plus4;

`ifdef IF_STAGE_MISALIGN_TRAP_EN
    assign redir_bad = redirect && (redirect_pc[1:0] != 2'b00);
`else
    assign redir_bad = 1'b0;
`endif
    // Without the trap, low bits are simply dropped so fetches stay word aligned.
    assign redir_tgt  = redir_bad ? TRAP_PC : (redirect_pc & ~32'd3);
    assign addr_plus4 = addr_q + 32'd4;

    assign imem.imem_req  = (state_q == REQ) || (state_q == DRAIN);
    assign imem.imem_addr = addr_q;
    assign valid_out      = valid_q;
    assign instr_out      = instr_q;
    assign next_pc_out    = npc_q;
    assign misalign       = misalign_q;
    assign dbg_state      = state_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            pc_q         <= RESET_PC;
            addr_q       <= RESET_PC;
            hold_instr_q <= 32'h0;
            hold_npc_q   <= 32'h0;
            instr_q      <= 32'h0;
            npc_q        <= 32'h0;
            valid_q      <= 1'b0;
            misalign_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            addr_q       <= addr_d;
            hold_instr_q <= hold_instr_d;
            hold_npc_q   <= hold_npc_d;
            instr_q      <= instr_d;
            npc_q        <= npc_d;
            valid_q      <= valid_d;
            misalign_q   <= misalign_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        addr_d       = addr_q;
        hold_instr_d = hold_instr_q;
        hold_npc_d   = hold_npc_q;
        instr_d      = instr_q;
        npc_d        = npc_q;
        valid_d      = 1'b0;
        misalign_d   = redir_bad;
        case (state_q)
            IDLE: begin
                state_d = REQ;
                if (redirect) begin
                    pc_d   = redir_tgt;
                    addr_d = redir_tgt;
                end else begin
                    addr_d = pc_q;
                end
            end
            REQ: begin
                if (redirect) begin
                    pc_d = redir_tgt;
                    // An unacknowledged request must still complete, so its word is drained.
                    if (imem.imem_ack) addr_d = redir_tgt;
                    else               state_d = DRAIN;
                end else if (imem.imem_ack) begin
                    pc_d = addr_plus4;
                    if (stall) begin
                        hold_instr_d = imem.imem_rdata;
                        hold_npc_d   = addr_plus4;
                        state_d      = HOLD;
                    end else begin
                        instr_d = imem.imem_rdata;
                        npc_d   = addr_plus4;
                        valid_d = 1'b1;
                        addr_d  = addr_plus4;
                    end
                end
            end
            HOLD: begin
                if (redirect) begin
                    pc_d         = redir_tgt;
                    addr_d       = redir_tgt;
                    hold_instr_d = 32'h0;
                    hold_npc_d   = 32'h0;
                    state_d      = REQ;
                end else if (!stall) begin
                    instr_d = hold_instr_q;
                    npc_d   = hold_npc_q;
                    valid_d = 1'b1;
                    addr_d  = pc_q;
                    state_d = REQ;
                end
            end
            DRAIN: begin
                if (redirect) pc_d = redir_tgt;
                if (imem.imem_ack) begin
                    addr_d  = redirect ? redir_tgt : pc_q;
                    state_d = REQ;
                end
            end
            default: state_d = IDLE;
        endcase
    end
endmodule
